pkt_truncator: RTL and testbench
================================

PKT_TRUNCATOR -- requirements
Module: pkt_truncator

Interface
REQ-001 Parameter DATA_WIDTH, 64, data bus width.
REQ-002 Parameter CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
REQ-003 Parameter CNT_WIDTH, 32, statistics counter width.
REQ-004 Port clk  input  1  clock. All logic is synchronous to clk.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in_data  input  DATA_WIDTH  upstream word, fed by the rate limiter stage.
REQ-007 Port in_ctrl  input  CTRL_WIDTH  upstream ctrl.
REQ-008 Port in_wr  input  1  upstream word valid.
REQ-009 Port in_rdy  output  1  ready to upstream; SHALL equal out_rdy combinationally.
REQ-010 Port out_data  output  DATA_WIDTH  registered data to downstream.
REQ-011 Port out_ctrl  output  CTRL_WIDTH  registered ctrl to downstream.
REQ-012 Port out_wr  output  1  registered write strobe.
REQ-013 Port out_rdy  input  1  downstream ready.
REQ-014 Port enable  input  1  truncation enable.
REQ-015 Port max_words  input  16  max payload words per packet, including the EOP word; 0 means no limit.
REQ-016 Port pkt_count  output  CNT_WIDTH  packets forwarded.
REQ-017 Port trunc_count  output  CNT_WIDTH  packets truncated.
REQ-018 Port drop_word_count  output  CNT_WIDTH  words discarded.

Function
REQ-019 A word is accepted only in cycles where in_wr=1; out_rdy is not used to qualify acceptance.
REQ-020 Each forwarded word SHALL appear on out_* exactly 1 cycle after acceptance, with out_wr=1 for one cycle; out_wr SHALL be 0 in all other cycles.
REQ-021 State HDR: a word with ctrl!=0 is a module header; it SHALL be forwarded unchanged and the state remains HDR.
REQ-022 HDR: a word with ctrl==0 is payload word 1, and the block SHALL latch enable and max_words into lim_en and lim on that cycle.
REQ-023 HDR: when lim_en=1 and lim==1, payload word 1 SHALL be forwarded with ctrl forced to 8'h01, pkt_count and trunc_count SHALL increment, and the state SHALL go to DISCARD.
REQ-024 HDR: otherwise payload word 1 SHALL be forwarded unchanged, word_cnt SHALL be set to 1, and the state SHALL go to PAYLOAD.
REQ-025 State PAYLOAD: a word with ctrl!=0 is the natural EOP; it SHALL be forwarded unchanged, pkt_count SHALL increment, and the state SHALL go to HDR.
REQ-026 PAYLOAD: a word with ctrl==0 when lim_en=1, lim!=0 and word_cnt+1==lim SHALL be forwarded with ctrl=8'h01, pkt_count and trunc_count SHALL increment, and the state SHALL go to DISCARD.
REQ-027 PAYLOAD: any other ctrl==0 word SHALL be forwarded unchanged and word_cnt SHALL increment.
REQ-028 word_cnt is 16 bits and SHALL saturate at 16'hFFFF.
REQ-029 State DISCARD: every accepted word SHALL be dropped (out_wr=0) and SHALL increment drop_word_count.
REQ-030 DISCARD: a dropped word with ctrl!=0 SHALL return the state to HDR.
REQ-031 A natural EOP that arrives on the word where word_cnt+1==lim is not truncation: trunc_count SHALL NOT increment.
REQ-032 Changes to enable or max_words during a packet SHALL take effect from the next packet only.
REQ-033 All counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-034 With lim_en=0 or lim==0, the block SHALL be a 1-cycle delay line that only counts packets.

Reset
REQ-035 While reset=1, the block SHALL clear out_wr, out_data, out_ctrl, pkt_count, trunc_count, drop_word_count, word_cnt, lim_en and lim to 0, and set the state to HDR.
REQ-036 A reset mid-packet SHALL abandon the packet; the words that follow SHALL be parsed from HDR.

Verification
REQ-037 enable=0: a packet of 1 header, 10 payload words and EOP ctrl 8'h04 -> all 12 words out unchanged at 1-cycle latency; pkt_count=1, trunc_count=0.
REQ-038 enable=1, max_words=4, packet of 1 header and 10 payload words -> 5 words out, the 5th with ctrl 8'h01; trunc_count=1; drop_word_count=6.
REQ-039 enable=1, max_words=4, packet with exactly 4 payload words (EOP ctrl 8'h10) -> all 5 words out unchanged; trunc_count=0.
REQ-040 enable=1, max_words=1 -> payload word 1 is output with ctrl 8'h01 and the rest are dropped; a back-to-back second packet is handled correctly.
REQ-041 max_words changed from 8 to 2 mid-packet -> the current packet uses 8, the next packet uses 2.
REQ-042 reset pulse during DISCARD -> all outputs and counters read 0; the next full packet passes correctly.

Source files
------------

// File: rtl/pkt_truncator.sv
// Packet truncator: forwards module headers and payload with one cycle of latency,
// cutting each packet at a per-packet word limit and discarding the remainder.
module pkt_truncator #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  enable,
  input  logic [15:0]           max_words,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  trunc_count,
  output logic [CNT_WIDTH-1:0]  drop_word_count
);

  // state    | meaning
  // S_HDR    | between packets / in module headers, waiting for payload word 1
  // S_PAYLOAD| forwarding payload, counting words against the latched limit
  // S_DISCARD| packet was cut; dropping words up to and including the EOP
  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [CTRL_WIDTH-1:0] CTRL_TRUNC = CTRL_WIDTH'(1);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q;
  logic                    out_wr_q;
  logic [CNT_WIDTH-1:0]    pkt_cnt_q;
  logic [CNT_WIDTH-1:0]    trunc_cnt_q;
  logic [CNT_WIDTH-1:0]    drop_cnt_q;
  logic [15:0]             word_cnt_q;
  logic                    lim_en_q;
  logic [15:0]             lim_q;

  logic                    ctrl_nz;
  logic                    at_limit;
  logic [15:0]             word_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign ctrl_nz    = (in_ctrl != '0);
  // 17-bit compare so a saturated word count can never alias onto a limit
  assign at_limit   = lim_en_q && (lim_q != 16'd0) &&
                      (({1'b0, word_cnt_q} + 17'd1) == {1'b0, lim_q});
  assign word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HDR;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      out_wr_q    <= 1'b0;
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
      drop_cnt_q  <= '0;
      word_cnt_q  <= '0;
      lim_en_q    <= 1'b0;
      lim_q       <= '0;
    end else begin
      out_wr_q <= 1'b0;
      if (in_wr) begin
        case (state_q)
          S_HDR: begin
            out_wr_q   <= 1'b1;
            out_data_q <= in_data;
            out_ctrl_q <= in_ctrl;
            if (!ctrl_nz) begin
              // payload word 1: the limit for this packet is sampled here
              lim_en_q <= enable;
              lim_q    <= max_words;
              if (enable && (max_words == 16'd1)) begin
                out_ctrl_q  <= CTRL_TRUNC;
                pkt_cnt_q   <= sat_inc(pkt_cnt_q);
                trunc_cnt_q <= sat_inc(trunc_cnt_q);
                state_q     <= S_DISCARD;
              end else begin
                word_cnt_q <= 16'd1;
                state_q    <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            out_wr_q   <= 1'b1;
            out_data_q <= in_data;
            out_ctrl_q <= in_ctrl;
            if (ctrl_nz) begin
              pkt_cnt_q <= sat_inc(pkt_cnt_q);
              state_q   <= S_HDR;
            end else if (at_limit) begin
              out_ctrl_q  <= CTRL_TRUNC;
              pkt_cnt_q   <= sat_inc(pkt_cnt_q);
              trunc_cnt_q <= sat_inc(trunc_cnt_q);
              state_q     <= S_DISCARD;
            end else begin
              word_cnt_q <= word_cnt_d;
            end
          end
          S_DISCARD: begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            if (ctrl_nz) begin
              state_q <= S_HDR;
            end
          end
          default: state_q <= S_HDR;
        endcase
      end
    end
  end

  assign in_rdy          = out_rdy;
  assign out_data        = out_data_q;
  assign out_ctrl        = out_ctrl_q;
  assign out_wr          = out_wr_q;
  assign pkt_count       = pkt_cnt_q;
  assign trunc_count     = trunc_cnt_q;
  assign drop_word_count = drop_cnt_q;

endmodule

// File: tb/tb_pkt_truncator.sv
// Randomized bench for pkt_truncator; expectations come from a per-packet model
// (forward min(len, limit) payload words, mark the cut word, drop the rest).
module tb_pkt_truncator;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        enable;
  logic [15:0] max_words;
  logic [31:0] pkt_count;
  logic [31:0] trunc_count;
  logic [31:0] drop_word_count;

  int checks = 0;
  int errors = 0;
  int m_pkt = 0;
  int m_trunc = 0;
  int m_drop = 0;

  pkt_truncator dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_ctrl         (in_ctrl),
    .in_wr           (in_wr),
    .in_rdy          (in_rdy),
    .out_data        (out_data),
    .out_ctrl        (out_ctrl),
    .out_wr          (out_wr),
    .out_rdy         (out_rdy),
    .enable          (enable),
    .max_words       (max_words),
    .pkt_count       (pkt_count),
    .trunc_count     (trunc_count),
    .drop_word_count (drop_word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_pkt"}, 64'(pkt_count), 64'(m_pkt));
    chk({tag, "_trunc"}, 64'(trunc_count), 64'(m_trunc));
    chk({tag, "_drop"}, 64'(drop_word_count), 64'(m_drop));
  endtask

  // One accepted word, optionally preceded by idle cycles; output checked 1 cycle later.
  task automatic send(input logic [63:0] d, input logic [7:0] c, input bit fwd,
                      input logic [7:0] ec);
    while ($urandom_range(0, 3) == 0) begin
      in_wr   = 1'b0;
      in_data = rnd64();
      in_ctrl = 8'($urandom);
      out_rdy = 1'($urandom);
      @(posedge clk);
      #1;
      chk("idle_out_wr", 64'(out_wr), 64'd0);
      chk("in_rdy", 64'(in_rdy), 64'(out_rdy));
    end
    in_wr   = 1'b1;
    in_data = d;
    in_ctrl = c;
    out_rdy = 1'($urandom);
    @(posedge clk);
    #1;
    chk("in_rdy", 64'(in_rdy), 64'(out_rdy));
    in_wr = 1'b0;
    chk("out_wr", 64'(out_wr), 64'(fwd));
    if (fwd) begin
      chk("out_data", out_data, d);
      chk("out_ctrl", 64'(out_ctrl), 64'(ec));
    end
  endtask

  task automatic do_reset();
    in_wr = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    m_pkt = 0;
    m_trunc = 0;
    m_drop = 0;
    chk_counters("rst");
    reset = 1'b0;
  endtask

  // npay counts payload words including the EOP. abort_after>0 resets after that many words.
  task automatic run_pkt(input int nhdr, input int npay, input bit en, input int mx,
                         input bit chg, input bit en2, input int mx2, input int abort_after);
    bit          trunc;
    int          sent;
    logic [7:0]  c;
    logic [7:0]  ec;
    enable    = en;
    max_words = 16'(mx);
    trunc = en && (mx != 0) && (npay > mx);
    sent = 0;
    for (int h = 0; h < nhdr; h++) begin
      c = 8'($urandom_range(1, 255));
      send(rnd64(), c, 1'b1, c);
      sent++;
      if (sent == abort_after) begin
        do_reset();
        return;
      end
    end
    for (int i = 1; i <= npay; i++) begin
      c  = (i == npay) ? 8'($urandom_range(1, 255)) : 8'h00;
      ec = (trunc && i == mx) ? 8'h01 : c;
      send(rnd64(), c, !trunc || (i <= mx), ec);
      sent++;
      if (i == 1 && chg) begin
        enable    = en2;
        max_words = 16'(mx2);
      end
      if (sent == abort_after) begin
        do_reset();
        return;
      end
    end
    m_pkt++;
    if (trunc) begin
      m_trunc++;
      m_drop += npay - mx;
    end
    chk_counters("pkt");
  endtask

  initial begin
    reset     = 1'b1;
    in_wr     = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_rdy   = 1'b1;
    enable    = 1'b0;
    max_words = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // enable off: plain delay line
    run_pkt(1, 11, 1'b0, 4, 1'b0, 1'b0, 0, 0);
    chk("d_noen_trunc", 64'(trunc_count), 64'd0);
    // cut at 4, six words dropped
    run_pkt(1, 10, 1'b1, 4, 1'b0, 1'b0, 0, 0);
    chk("d_cut4_drop", 64'(drop_word_count), 64'd6);
    // EOP exactly at the limit is not a truncation
    run_pkt(1, 4, 1'b1, 4, 1'b0, 1'b0, 0, 0);
    chk("d_exact_trunc", 64'(trunc_count), 64'd1);
    // limit of one, back to back
    run_pkt(1, 5, 1'b1, 1, 1'b0, 1'b0, 0, 0);
    run_pkt(0, 3, 1'b1, 1, 1'b0, 1'b0, 0, 0);
    // mid-packet limit change applies only to the next packet
    run_pkt(1, 10, 1'b1, 8, 1'b1, 1'b1, 2, 0);
    run_pkt(1, 10, 1'b1, 2, 1'b0, 1'b0, 0, 0);
    // limit zero means unlimited
    run_pkt(2, 7, 1'b1, 0, 1'b0, 1'b0, 0, 0);
    // reset while discarding, then a clean packet
    run_pkt(1, 8, 1'b1, 2, 1'b0, 1'b0, 0, 5);
    run_pkt(1, 6, 1'b1, 3, 1'b0, 1'b0, 0, 0);

    for (int p = 0; p < 60; p++) begin
      run_pkt($urandom_range(0, 2), $urandom_range(2, 12), 1'($urandom),
              $urandom_range(0, 12), 1'($urandom), 1'($urandom),
              $urandom_range(0, 12), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
